// File: rtl/spiflash_target_if.sv
`default_nettype none
// ============================================================================
// Module   : spiflash_target_if
// Purpose  : Bundles the SPI flash pins and the byte-memory read port of
//            spiflash_target.
//   slave  modport : the flash emulator (drives io/oe, memory requests, status)
//   master modport : the host/system side (drives csb/sck/io in, memory reply)
// Ports    : spi_csb, spi_clk, spi_io_di[3:0], spi_io_do[3:0], spi_io_oe[3:0],
//            mem_valid, mem_ready, mem_addr[23:0], mem_rdata[7:0],
//            cont_mode, underrun, last_cmd[7:0]
// Revision : 1.0 - initial release
// ============================================================================
interface spiflash_target_if;
  logic        spi_csb;
  logic        spi_clk;
  logic [3:0]  spi_io_di;
  logic [3:0]  spi_io_do;
  logic [3:0]  spi_io_oe;
  logic        mem_valid;
  logic        mem_ready;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        cont_mode;
  logic        underrun;
  logic [7:0]  last_cmd;

  modport slave (
    input  spi_csb, spi_clk, spi_io_di, mem_ready, mem_rdata,
    output spi_io_do, spi_io_oe, mem_valid, mem_addr, cont_mode, underrun, last_cmd
  );

  modport master (
    output spi_csb, spi_clk, spi_io_di, mem_ready, mem_rdata,
    input  spi_io_do, spi_io_oe, mem_valid, mem_addr, cont_mode, underrun, last_cmd
  );
endinterface
`default_nettype wire

// File: rtl/spiflash_target.sv
`default_nettype none
// ============================================================================
// Module   : spiflash_target
// Purpose  : SPI NOR flash target emulator. Oversamples the SPI pins in the
//            clk domain and serves 0x03 (single read) and 0xEB (quad I/O read,
//            with continuous mode) from a byte-wide memory read port.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous, active-high
//            bus   - spiflash_target_if.slave (SPI pins, memory port, status)
// Revision : 1.0 - initial release
// ============================================================================
module spiflash_target #(
  parameter int DUMMY_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  spiflash_target_if.slave    bus
);

  localparam logic [4:0] C_DUMMY_LAST = 5'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_IGNORE
  } state_t;

  // Pin synchronisers; stage 3 only exists for edge detection.
  logic       csb_s1_q, csb_s2_q, csb_s3_q;
  logic       sck_s1_q, sck_s2_q, sck_s3_q;
  logic [3:0] io_s1_q, io_s2_q;

  state_t      state_q,     state_d;
  logic        quad_q,      quad_d;
  logic        from_cont_q, from_cont_d;   // frame began without a command byte
  logic [4:0]  bit_cnt_q,   bit_cnt_d;
  logic [22:0] shift_in_q,  shift_in_d;
  logic [7:0]  out_q,       out_d;
  logic [2:0]  out_cnt_q,   out_cnt_d;     // units left in out_q; 0 = need a byte
  logic [7:0]  buf_q,       buf_d;
  logic        buf_valid_q, buf_valid_d;
  logic        live_q,      live_d;        // outstanding request belongs to this frame
  logic [3:0]  do_q,        do_d;
  logic [3:0]  oe_q,        oe_d;
  logic        mem_valid_q, mem_valid_d;
  logic [23:0] mem_addr_q,  mem_addr_d;
  logic        cont_mode_q, cont_mode_d;
  logic        underrun_q,  underrun_d;
  logic [7:0]  last_cmd_q,  last_cmd_d;

  logic        sck_rise, sck_fall, csb_fall;
  logic [23:0] shift1, shift4;
  logic [7:0]  byte_v;

  always_comb begin
    sck_rise = sck_s2_q & ~sck_s3_q;
    sck_fall = ~sck_s2_q & sck_s3_q;
    csb_fall = ~csb_s2_q & csb_s3_q;
    shift1   = {shift_in_q, io_s2_q[0]};
    shift4   = {shift_in_q[19:0], io_s2_q};
    byte_v   = out_q;

    state_d     = state_q;
    quad_d      = quad_q;
    from_cont_d = from_cont_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    out_d       = out_q;
    out_cnt_d   = out_cnt_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    live_d      = live_q;
    do_d        = do_q;
    oe_d        = oe_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    cont_mode_d = cont_mode_q;
    underrun_d  = underrun_q;
    last_cmd_d  = last_cmd_q;

    // A request always completes; its data is kept only if the frame is still live.
    if (mem_valid_q && bus.mem_ready) begin
      mem_valid_d = 1'b0;
      if (live_q) begin
        buf_d       = bus.mem_rdata;
        buf_valid_d = 1'b1;
      end
    end

    if (csb_s2_q) begin
      // A continuous-mode frame aborted before the dummy phase ends is the
      // host's way of leaving continuous mode.
      if (from_cont_q && (state_q == S_ADDR || state_q == S_MODE || state_q == S_DUMMY))
        cont_mode_d = 1'b0;
      state_d     = S_IDLE;
      oe_d        = 4'b0000;
      do_d        = 4'b0000;
      bit_cnt_d   = 5'd0;
      live_d      = 1'b0;
      buf_valid_d = 1'b0;
      out_cnt_d   = 3'd0;
      from_cont_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (csb_fall) begin
            bit_cnt_d = 5'd0;
            if (cont_mode_q) begin
              state_d     = S_ADDR;
              quad_d      = 1'b1;
              from_cont_d = 1'b1;
            end else begin
              state_d     = S_CMD;
              from_cont_d = 1'b0;
            end
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            shift_in_d = shift1[22:0];
            bit_cnt_d  = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d  = 5'd0;
              last_cmd_d = shift1[7:0];
              case (shift1[7:0])
                8'h03: begin state_d = S_ADDR; quad_d = 1'b0; end
                8'hEB: begin state_d = S_ADDR; quad_d = 1'b1; end
                8'hFF: begin state_d = S_IGNORE; cont_mode_d = 1'b0; end
                default: state_d = S_IGNORE;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            shift_in_d = quad_q ? shift4[22:0] : shift1[22:0];
            bit_cnt_d  = bit_cnt_q + 5'd1;
            if ((quad_q && bit_cnt_q == 5'd5) || (!quad_q && bit_cnt_q == 5'd23)) begin
              bit_cnt_d   = 5'd0;
              mem_addr_d  = quad_q ? shift4 : shift1;
              mem_valid_d = 1'b1;
              live_d      = 1'b1;
              buf_valid_d = 1'b0;
              out_cnt_d   = 3'd0;
              state_d     = quad_q ? S_MODE : S_DATA;
            end
          end
        end
        S_MODE: begin
          if (sck_rise) begin
            shift_in_d = shift4[22:0];
            bit_cnt_d  = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd1) begin
              bit_cnt_d   = 5'd0;
              cont_mode_d = (shift4[7:0] == 8'hA5);
              state_d     = S_DUMMY;
            end
          end
        end
        S_DUMMY: begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == C_DUMMY_LAST) begin
              bit_cnt_d = 5'd0;
              state_d   = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (sck_fall) begin
            if (out_cnt_q == 3'd0) begin
              if (buf_valid_q) begin
                // Consume the buffered byte and prefetch the next one.
                byte_v      = buf_q;
                buf_valid_d = 1'b0;
                mem_addr_d  = mem_addr_q + 24'd1;
                mem_valid_d = 1'b1;
              end else begin
                byte_v     = 8'hFF;
                underrun_d = 1'b1;
              end
            end
            if (quad_q) begin
              do_d      = byte_v[7:4];
              out_d     = {byte_v[3:0], 4'h0};
              oe_d      = 4'b1111;
              out_cnt_d = (out_cnt_q == 3'd0) ? 3'd1 : out_cnt_q - 3'd1;
            end else begin
              do_d      = {2'b00, byte_v[7], 1'b0};
              out_d     = {byte_v[6:0], 1'b0};
              oe_d      = 4'b0010;
              out_cnt_d = (out_cnt_q == 3'd0) ? 3'd7 : out_cnt_q - 3'd1;
            end
          end
        end
        S_IGNORE: oe_d = 4'b0000;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csb_s1_q <= 1'b1; csb_s2_q <= 1'b1; csb_s3_q <= 1'b1;
      sck_s1_q <= 1'b0; sck_s2_q <= 1'b0; sck_s3_q <= 1'b0;
      io_s1_q  <= 4'h0; io_s2_q  <= 4'h0;
      state_q     <= S_IDLE;
      quad_q      <= 1'b0;
      from_cont_q <= 1'b0;
      bit_cnt_q   <= 5'd0;
      shift_in_q  <= 23'd0;
      out_q       <= 8'h00;
      out_cnt_q   <= 3'd0;
      buf_q       <= 8'h00;
      buf_valid_q <= 1'b0;
      live_q      <= 1'b0;
      do_q        <= 4'h0;
      oe_q        <= 4'h0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 24'd0;
      cont_mode_q <= 1'b0;
      underrun_q  <= 1'b0;
      last_cmd_q  <= 8'h00;
    end else begin
      csb_s1_q <= bus.spi_csb;   csb_s2_q <= csb_s1_q; csb_s3_q <= csb_s2_q;
      sck_s1_q <= bus.spi_clk;   sck_s2_q <= sck_s1_q; sck_s3_q <= sck_s2_q;
      io_s1_q  <= bus.spi_io_di; io_s2_q  <= io_s1_q;
      state_q     <= state_d;
      quad_q      <= quad_d;
      from_cont_q <= from_cont_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      out_q       <= out_d;
      out_cnt_q   <= out_cnt_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      live_q      <= live_d;
      do_q        <= do_d;
      oe_q        <= oe_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      cont_mode_q <= cont_mode_d;
      underrun_q  <= underrun_d;
      last_cmd_q  <= last_cmd_d;
    end
  end

  assign bus.spi_io_do = do_q;
  assign bus.spi_io_oe = oe_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.cont_mode = cont_mode_q;
  assign bus.underrun  = underrun_q;
  assign bus.last_cmd  = last_cmd_q;

endmodule
`default_nettype wire

// File: doc/spiflash_target.md
# spiflash_target

Synchronous SPI NOR flash target emulator: presents a flash-compatible responder on the SPI pins and serves read data from an on-chip byte memory port. It is the counterpart to the PicoSoC QSPI flash controller, supporting single read (0x03), quad I/O read (0xEB) with continuous mode, and the 0xAB/0xFF housekeeping commands. It is used on FPGA test fabric and in SoC simulation to stand in for an external flash. SPI pins are oversampled in the `clk` domain; there is no SCK-clocked logic.

## Interface
- `DUMMY_CYCLES`, default 8: SCK cycles between the mode byte and the first data nibble for 0xEB; legal range 1..15.
- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `spi_csb` input 1: chip select, active low, asynchronous to `clk`.
- `spi_clk` input 1: SCK, mode 0, asynchronous to `clk`.
- `spi_io_di` input 4: io3..io0 pin inputs.
- `spi_io_do` output 4: io3..io0 drive values.
- `spi_io_oe` output 4: io3..io0 output enables.
- `mem_valid` output 1: byte read request.
- `mem_ready` input 1: request accepted; `mem_rdata` valid in the same cycle.
- `mem_addr` output 24: byte address.
- `mem_rdata` input 8: read data.
- `cont_mode` output 1: continuous-read mode armed.
- `underrun` output 1: sticky; set when data was needed before memory returned it.
- `last_cmd` output 8: last accepted command byte.

## Operation
- Input sync: `spi_csb`, `spi_clk` and `spi_io_di` each pass through 2 flops. Edges are detected against a third flop. A rise samples the synced io; a fall shifts the output.
- Synced `spi_csb`=1 forces IDLE immediately, drives `spi_io_oe`=0 and clears the bit counter. It can arrive at any point mid-frame.
- States:
  - IDLE: on CSB fall go to ADDR if `cont_mode`, else CMD.
  - CMD: 8 single-bit rises on io0, MSB first.
    - 0x03 → ADDR (single).
    - 0xEB → ADDR (quad).
    - 0xAB, 0xFF → IGNORE. 0xFF also clears `cont_mode`.
    - Any other value → IGNORE.
    - `last_cmd` updates for every completed byte.
  - ADDR: single mode takes 24 rises on io0; quad mode takes 6 rises, nibble = io3..io0, MSB first. Next: single → DATA; quad → MODE.
  - MODE: 2 quad rises. Mode byte 0xA5 sets `cont_mode`; any other value clears it. Next: DUMMY.
  - DUMMY: ignore `DUMMY_CYCLES` rises, then go to DATA.
  - DATA: shift bytes out MSB first until CSB rises.
    - Single: io1 only, `spi_io_oe`=4'b0010.
    - Quad: `spi_io_oe`=4'b1111, nibble on io3..io0.
  - IGNORE: all oe=0; wait for CSB high.
- Continuous frames: a frame starting in ADDR that sees CSB rise before DUMMY completes clears `cont_mode`. This covers the host's 0xFF exit sequence.
- Memory port:
  - A request for the start address is issued the cycle after the last address bit is sampled.
  - When a byte is loaded into the shift register, a request for address+1 is issued immediately (one-byte prefetch).
  - The address is 24-bit and wraps: 0xFFFFFF+1 = 0x000000.
  - `mem_valid` is held until `mem_ready`. A request in flight when CSB rises completes, and its data is discarded.
- Underrun: if DATA needs a new byte at a falling edge and no byte is buffered, `underrun` is set and the byte 0xFF is shifted instead. `underrun` is cleared only by `reset`.
- First data bit: it is driven on the SCK fall that follows the last ADDR rise (single) or the last DUMMY rise (quad).

## Timing
- Reset values:
  - `spi_io_oe`=0, `spi_io_do`=0.
  - `mem_valid`=0, `mem_addr`=0.
  - `cont_mode`=0, `underrun`=0, `last_cmd`=0.
  - State is IDLE; the sync flops are set to csb=1, clk=0.
- Pin edge to action:
  - A pin SCK rise is sampled in the 3rd `clk` cycle after it.
  - A pin SCK fall updates `spi_io_do` 3 cycles after it.
  - `spi_io_oe` changes 3 cycles after the qualifying SCK fall or CSB rise.
- SCK high and low phases must each be ≥4 `clk` cycles. Host io setup and hold around the SCK rise must be ≥3 `clk` cycles.
- Memory latency: from the request (`mem_valid` high) to `mem_ready` must be shorter than the high phase minus 3 cycles for 0x03; otherwise an underrun occurs.
- If CSB rise and SCK fall arrive in the same cycle, CSB wins: no shift happens and oe goes to 0.
- Async `reset` mid-frame clears everything in the same cycle. The next frame must start from CSB high.

## Test plan
- 0x03, address 0x000010, memory[i]=i[7:0], 16 data clocks → io1 returns 0x10 then 0x11 MSB first; `mem_addr` is 0x000010 then 0x000011; `spi_io_oe`=4'b0010 only in DATA.
- 0xEB, address 0x123456, mode 0xA5, 8 dummy clocks, 4 data clocks → nibbles of memory[0x123456..0x123457] on io3..io0; `cont_mode`=1. The next frame, sent without a command byte, reads address 0x000100 correctly.
- In `cont_mode`, host sends 8 clocks with all io=1, then CSB high → `cont_mode`=0. The next frame decodes 0x03 as a command.
- 0x03 at address 0xFFFFFF, 2 bytes → `mem_addr` is 0xFFFFFF then 0x000000; the data matches memory.
- `mem_ready` held low for 20 cycles with SCK phase = 4 cycles → `underrun`=1 and the first byte reads 0xFF. `underrun` stays set until `reset`.
- CSB rises mid-address, and separately async `reset` is asserted mid-DATA → oe=0 within 3 cycles (or immediately for reset); state IDLE; a follow-up 0x03 read returns correct data; 0x5A leaves all oe=0 and sets `last_cmd`=0x5A.
